// File: rtl/accel_sched_pkg.sv
// Shared types and default widths for the M/N wave scheduler and its counter chain.
package accel_sched_pkg;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_KWIDTH      = 8;
  localparam int DEFAULT_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } sched_state_e;

endpackage

// File: rtl/sched_watchdog.sv
// Wave watchdog: counts cycles spent waiting for the chain and flags a stall.
// Only instantiated when SCHED_WATCHDOG_EN is defined.
module sched_watchdog #(
  parameter int Timeout_Cyc = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wait_i,
  input  logic done_i,
  output logic timeout_o
);

  localparam int CntW = $clog2(Timeout_Cyc + 1);

  logic [CntW-1:0] r_cnt;

  // The count restarts on every wave exit, so each pass gets its own budget.
  always_ff @(posedge clk_i) begin
    if (rst_i || !wait_i || done_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign timeout_o = wait_i && !done_i && (r_cnt == CntW'(Timeout_Cyc - 1));

endmodule

// File: rtl/mn_wave_scheduler.sv
// Job-level controller that launches one wave per K pass into the M/N counter chain.
// Optional stall watchdog enabled by defining SCHED_WATCHDOG_EN.
module mn_wave_scheduler
  import accel_sched_pkg::*;
#(
  parameter int Width       = DEFAULT_WIDTH,
  parameter int Kwidth      = DEFAULT_KWIDTH,
  parameter int Timeout_Cyc = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [Width-1:0]  cfg_m_size_i,
  input  logic [Width-1:0]  cfg_n_size_i,
  input  logic [Kwidth-1:0] cfg_k_passes_i,
  input  logic              abort_i,
  output logic              ctr_start_o,
  output logic [Width-1:0]  ctr_m_size_o,
  output logic [Width-1:0]  ctr_n_size_o,
  input  logic              ctr_done_i,
  output logic              busy_o,
  output logic [Kwidth-1:0] pass_cnt_o,
  output logic              job_done_o,
  output logic              err_o
);

  sched_state_e      r_state;
  sched_state_e      w_next_state;
  logic [Width-1:0]  r_m_size;
  logic [Width-1:0]  r_n_size;
  logic [Kwidth-1:0] r_k_passes;
  logic [Kwidth-1:0] r_pass_cnt;
  logic [Kwidth-1:0] w_pass_next;
  logic              w_accept;
  logic              w_pass_inc;
  logic              w_in_wait;
  logic              w_timeout;
  logic              w_start;
  logic              w_job_done;
  logic              w_ready;
  logic              w_busy;

  assign w_in_wait   = (r_state == WAIT);
  assign w_accept    = (r_state == IDLE) && cfg_valid_i;
  assign w_pass_next = r_pass_cnt + Kwidth'(1);
  assign w_pass_inc  = w_in_wait && ctr_done_i && !abort_i && !w_timeout;

`ifdef SCHED_WATCHDOG_EN
  logic r_err;

  sched_watchdog #(
    .Timeout_Cyc(Timeout_Cyc)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wait_i   (w_in_wait),
    .done_i   (ctr_done_i),
    .timeout_o(w_timeout)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (Timeout_Cyc > 0);
  assign w_timeout        = 1'b0;
  assign err_o            = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_m_size   <= '0;
      r_n_size   <= '0;
      r_k_passes <= '0;
      r_pass_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_m_size   <= cfg_m_size_i;
        r_n_size   <= cfg_n_size_i;
        r_k_passes <= cfg_k_passes_i;
        r_pass_cnt <= '0;
      end else if (w_pass_inc) begin
        r_pass_cnt <= w_pass_next;
      end
    end
  end

  // Abort and watchdog expiry override any transition; a START cycle still emits its pulse.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_job_done   = 1'b0;
    w_ready      = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
        if (cfg_valid_i) begin
          w_next_state = (cfg_k_passes_i != '0) ? START : DONE;
        end
      end
      START: begin
        w_start      = 1'b1;
        w_next_state = WAIT;
      end
      WAIT: begin
        if (ctr_done_i) begin
          w_next_state = (w_pass_next == r_k_passes) ? DONE : START;
        end
      end
      DONE: begin
        w_job_done   = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    if ((r_state != IDLE) && (abort_i || w_timeout)) begin
      w_next_state = IDLE;
    end
  end

  assign cfg_ready_o  = w_ready;
  assign busy_o       = w_busy;
  assign ctr_start_o  = w_start;
  assign job_done_o   = w_job_done;
  assign ctr_m_size_o = r_m_size;
  assign ctr_n_size_o = r_n_size;
  assign pass_cnt_o   = r_pass_cnt;

endmodule
